// File: rtl/div_iter_unit_if.sv
// Request/response bundle between the EX stage (master) and the iterative divider (slave).
interface div_iter_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            is_q_i;
    logic            ready_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output req_i, a_i, b_i, is_q_i,
        input  ready_o, result_o
    );

    modport slave (
        input  req_i, a_i, b_i, is_q_i,
        output ready_o, result_o
    );
endinterface

// File: rtl/div_iter_unit.sv
// Iterative unsigned radix-2 restoring divider returning quotient or remainder.
// Optional DIV_RESULT_CACHE_EN reuses the last completed result for repeated operands.
module div_iter_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    div_iter_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    // Dividend shifts out of the MSB while quotient bits shift into the LSB.
    logic [XLEN-1:0] dq_q, dq_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            isq_q, isq_d;
    logic [XLEN-1:0] result_q, result_d;

`ifdef DIV_RESULT_CACHE_EN
    logic [XLEN-1:0] ca_a_q, ca_a_d;
    logic [XLEN-1:0] ca_quo_q, ca_quo_d;
    logic [XLEN-1:0] ca_rem_q, ca_rem_d;
    logic            ca_valid_q, ca_valid_d;
    logic            ca_hit;
`endif

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_sub;
    logic            take;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;

    always_comb begin
        rem_shift = {rem_q, dq_q[XLEN-1]};
        rem_sub   = rem_shift - {1'b0, div_q};
        take      = (rem_shift >= {1'b0, div_q});
        rem_next  = take ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_next  = {dq_q[XLEN-2:0], take};
    end

`ifdef DIV_RESULT_CACHE_EN
    // div_q still holds the divisor of the last accepted operation.
    assign ca_hit = ca_valid_q && (bus.a_i == ca_a_q) && (bus.b_i == div_q);
`endif

    always_comb begin
        state_d     = state_q;
        dq_d        = dq_q;
        div_d       = div_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        isq_d       = isq_q;
        result_d    = result_q;
        bus.ready_o = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
        ca_a_d      = ca_a_q;
        ca_quo_d    = ca_quo_q;
        ca_rem_d    = ca_rem_q;
        ca_valid_d  = ca_valid_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req_i) begin
`ifdef DIV_RESULT_CACHE_EN
                    if (ca_hit) begin
                        state_d  = StDone;
                        result_d = bus.is_q_i ? ca_quo_q : ca_rem_q;
                    end else begin
                        state_d    = StBusy;
                        dq_d       = bus.a_i;
                        div_d      = bus.b_i;
                        isq_d      = bus.is_q_i;
                        rem_d      = '0;
                        cnt_d      = '0;
                        ca_a_d     = bus.a_i;
                        ca_valid_d = 1'b0;
                    end
`else
                    state_d = StBusy;
                    dq_d    = bus.a_i;
                    div_d   = bus.b_i;
                    isq_d   = bus.is_q_i;
                    rem_d   = '0;
                    cnt_d   = '0;
`endif
                end
            end
            StBusy: begin
                if (!bus.req_i) begin
                    // EX flush: drop the operation without a ready pulse.
                    state_d = StIdle;
`ifdef DIV_RESULT_CACHE_EN
                    ca_valid_d = 1'b0;
`endif
                end else begin
                    dq_d  = quo_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        state_d  = StDone;
                        result_d = isq_q ? quo_next : rem_next;
`ifdef DIV_RESULT_CACHE_EN
                        ca_quo_d   = quo_next;
                        ca_rem_d   = rem_next;
                        ca_valid_d = 1'b1;
`endif
                    end
                end
            end
            StDone: begin
                bus.ready_o = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.result_o = result_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            dq_q       <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            isq_q      <= 1'b0;
            result_q   <= '0;
`ifdef DIV_RESULT_CACHE_EN
            ca_a_q     <= '0;
            ca_quo_q   <= '0;
            ca_rem_q   <= '0;
            ca_valid_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dq_q       <= dq_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            isq_q      <= isq_d;
            result_q   <= result_d;
`ifdef DIV_RESULT_CACHE_EN
            ca_a_q     <= ca_a_d;
            ca_quo_q   <= ca_quo_d;
            ca_rem_q   <= ca_rem_d;
            ca_valid_q <= ca_valid_d;
`endif
        end
    end
endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit at XLEN=32.
module tb_div_iter_unit;
    localparam int unsigned XLEN = 32;
`ifdef DIV_RESULT_CACHE_EN
    localparam int HitLat = 2;
`else
    localparam int HitLat = 34;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    div_iter_unit_if #(.XLEN(XLEN)) bus ();

    div_iter_unit #(.XLEN(XLEN)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        q;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic q);
        bus.a_i    = a;
        bus.b_i    = b;
        bus.is_q_i = q;
        bus.req_i  = 1'b1;
    endtask

    // Counts rising edges until ready_o is seen; -1 if it never comes.
    task automatic wait_ready(output logic [31:0] res, output int edges);
        bit seen = 1'b0;
        edges = 0;
        res   = '0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.ready_o) begin
                res  = bus.result_o;
                seen = 1'b1;
            end
        end
        if (!seen) edges = -1;
    endtask

    // Latency is reported as cycles of req high including the ready cycle.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic q, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          edges;
        start(a, b, q);
        wait_ready(res, edges);
        bus.req_i = 1'b0;
        check({tag, "_res"}, res, exp);
        check({tag, "_lat"}, 32'(edges + 1), 32'(exp_lat));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(bus.ready_o), 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          edges;
        vec_t        vecs[8];

        vecs[0] = '{32'd5,        32'd9,        1'b1, 32'd0};
        vecs[1] = '{32'd5,        32'd9,        1'b0, 32'd5};
        vecs[2] = '{32'hFFFFFFFF, 32'd1,        1'b1, 32'hFFFFFFFF};
        vecs[3] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'd0};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd1};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0};
        vecs[6] = '{32'hFFFFFFFF, 32'h80000001, 1'b1, 32'd1};
        vecs[7] = '{32'hFFFFFFFF, 32'h80000001, 1'b0, 32'h7FFFFFFE};

        rst_n      = 1'b0;
        bus.req_i  = 1'b0;
        bus.a_i    = '0;
        bus.b_i    = '0;
        bus.is_q_i = 1'b0;
        #12;
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op("q100_7", 32'd100, 32'd7, 1'b1, 32'd14, 34);
        op("r100_7", 32'd100, 32'd7, 1'b0, 32'd2, HitLat);

        // Divide by zero, with operands scrambled mid-BUSY.
        start(32'h12345678, 32'd0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        bus.a_i    = 32'hDEADBEEF;
        bus.b_i    = 32'd3;
        bus.is_q_i = 1'b0;
        wait_ready(res, edges);
        bus.req_i = 1'b0;
        check("dz_q_res", res, 32'hFFFFFFFF);
        check("dz_q_lat", 32'(edges + 5 + 1), 32'd34);
        @(posedge clk);
        #1;
        op("dz_r", 32'h12345678, 32'd0, 1'b0, 32'h12345678, HitLat);

        for (int i = 0; i < 8; i++) begin
            start(vecs[i].a, vecs[i].b, vecs[i].q);
            wait_ready(res, edges);
            bus.req_i = 1'b0;
            check($sformatf("vec%0d", i), res, vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Abort at BUSY cycle 10.
        start(32'd1000, 32'd3, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        bus.req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("abort_ready", 32'(bus.ready_o), 32'd0);
        end
        check("abort_result", bus.result_o, 32'h7FFFFFFE);
        op("after_abort", 32'd50, 32'd5, 1'b1, 32'd10, 34);

        // Back-to-back: req stays high across the ready cycle.
        start(32'd100, 32'd7, 1'b1);
        wait_ready(res, edges);
        check("b2b1_res", res, 32'd14);
        check("b2b1_lat", 32'(edges + 1), 32'd34);
        bus.is_q_i = 1'b0;
        wait_ready(res, edges);
        bus.req_i = 1'b0;
        check("b2b2_res", res, 32'd2);
        check("b2b2_lat", 32'(edges), 32'(HitLat));
        @(posedge clk);
        #1;

        // Asynchronous reset mid-BUSY.
        start(32'd1000, 32'd3, 1'b1);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(bus.ready_o), 32'd0);
        check("arst_result", bus.result_o, 32'd0);
        bus.req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_idle_ready", 32'(bus.ready_o), 32'd0);
        op("q81_9", 32'd81, 32'd9, 1'b1, 32'd9, 34);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end
endmodule
